// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK levels, R/W encoding.
// Used by i2c_slave_fsm and reusable by the master controller.
package i2c_pkg;

    localparam int DATA_SIZE_DEF = 8;

    localparam logic ACK     = 1'b0;
    localparam logic NACK    = 1'b1;
    localparam logic RW_READ = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } slv_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// 2-flop synchronisers for SCL/SDA plus edge and START/STOP condition pulses.
// Flops reset to 1 so an idle (pulled-up) bus produces no spurious events.
module i2c_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0] r_scl_ff;
    logic [1:0] r_sda_ff;
    logic       r_scl_q;
    logic       r_sda_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scl_ff <= 2'b11;
            r_sda_ff <= 2'b11;
            r_scl_q  <= 1'b1;
            r_sda_q  <= 1'b1;
        end else begin
            r_scl_ff <= {r_scl_ff[0], scl_i};
            r_sda_ff <= {r_sda_ff[0], sda_i};
            r_scl_q  <= r_scl_ff[1];
            r_sda_q  <= r_sda_ff[1];
        end
    end

    assign scl_o      = r_scl_ff[1];
    assign sda_o      = r_sda_ff[1];
    assign scl_rise_o = r_scl_ff[1] & ~r_scl_q;
    assign scl_fall_o = ~r_scl_ff[1] & r_scl_q;
    // SCL must be high on both samples so an SCL edge never looks like a condition
    assign start_o    = r_scl_q & r_scl_ff[1] & r_sda_q & ~r_sda_ff[1];
    assign stop_o     = r_scl_q & r_scl_ff[1] & ~r_sda_q & r_sda_ff[1];

endmodule

// File: rtl/i2c_slave_fsm.sv
// I2C target controller: address match, write receive, read transmit.
// Optional clock stretching enabled by defining I2C_SLAVE_CLK_STRETCH_EN.
module i2c_slave_fsm
    import i2c_pkg::*;
#(
    parameter int                  DATA_SIZE  = DATA_SIZE_DEF,
    parameter int                  ADDR_SIZE  = 7,
    parameter logic [ADDR_SIZE-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic                 i2c_core_clk_i,
    input  logic                 reset_ni,
    input  logic                 i2c_scl_i,
    input  logic                 i2c_sda_i,
    output logic                 i2c_sda_en_o,
    output logic                 i2c_scl_en_o,
    output logic [DATA_SIZE-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    input  logic [DATA_SIZE-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 addressed_o,
    output logic                 rw_o,
    output logic                 stop_o,
    output logic                 underrun_o
);

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    localparam bit STRETCH = 1'b1;
`else
    localparam bit STRETCH = 1'b0;
`endif

    logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop;

    i2c_line_sync u_sync (
        .clk_i      (i2c_core_clk_i),
        .rst_ni     (reset_ni),
        .scl_i      (i2c_scl_i),
        .sda_i      (i2c_sda_i),
        .scl_o      (w_scl),
        .sda_o      (w_sda),
        .scl_rise_o (w_rise),
        .scl_fall_o (w_fall),
        .start_o    (w_start),
        .stop_o     (w_stop)
    );

    slv_state_e           r_state, w_state;
    logic [2:0]           r_bitcnt, w_bitcnt;
    logic [DATA_SIZE-1:0] r_shift, w_shift;
    logic [DATA_SIZE-1:0] r_rx_data, w_rx_data;
    logic                 r_rw, w_rw;
    logic                 r_addressed, w_addressed;
    logic                 r_sda_en, w_sda_en;
    logic                 r_scl_en, w_scl_en;
    logic                 r_ackph, w_ackph;
    logic                 r_rx_ok, w_rx_ok;
    logic                 r_wait, w_wait;
    logic                 r_rx_valid, w_rx_valid;
    logic                 r_tx_ready, w_tx_ready;
    logic                 r_underrun, w_underrun;
    logic                 r_stop, w_stop_p;
    logic                 w_load;
    logic [DATA_SIZE-1:0] w_byte_ld;
    logic [DATA_SIZE-1:0] w_shift_in;

    always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= 3'd7;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rw        <= 1'b0;
            r_addressed <= 1'b0;
            r_sda_en    <= 1'b0;
            r_scl_en    <= 1'b0;
            r_ackph     <= 1'b0;
            r_rx_ok     <= 1'b0;
            r_wait      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_underrun  <= 1'b0;
            r_stop      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_bitcnt    <= w_bitcnt;
            r_shift     <= w_shift;
            r_rx_data   <= w_rx_data;
            r_rw        <= w_rw;
            r_addressed <= w_addressed;
            r_sda_en    <= w_sda_en;
            r_scl_en    <= w_scl_en;
            r_ackph     <= w_ackph;
            r_rx_ok     <= w_rx_ok;
            r_wait      <= w_wait;
            r_rx_valid  <= w_rx_valid;
            r_tx_ready  <= w_tx_ready;
            r_underrun  <= w_underrun;
            r_stop      <= w_stop_p;
        end
    end

    assign w_byte_ld  = tx_valid_i ? tx_data_i : {DATA_SIZE{1'b1}};
    assign w_shift_in = {r_shift[DATA_SIZE-2:0], w_sda};

    always_comb begin
        w_state     = r_state;
        w_bitcnt    = r_bitcnt;
        w_shift     = r_shift;
        w_rx_data   = r_rx_data;
        w_rw        = r_rw;
        w_addressed = r_addressed;
        w_sda_en    = r_sda_en;
        w_scl_en    = r_scl_en;
        w_ackph     = r_ackph;
        w_rx_ok     = r_rx_ok;
        w_wait      = r_wait;
        w_rx_valid  = 1'b0;
        w_tx_ready  = 1'b0;
        w_underrun  = 1'b0;
        w_stop_p    = 1'b0;
        w_load      = 1'b0;

        if (w_start) begin
            w_state     = ST_ADDR;
            w_bitcnt    = 3'd7;
            w_sda_en    = 1'b0;
            w_scl_en    = 1'b0;
            w_wait      = 1'b0;
            w_addressed = 1'b0;
        end else if (w_stop) begin
            w_state     = ST_IDLE;
            w_sda_en    = 1'b0;
            w_scl_en    = 1'b0;
            w_wait      = 1'b0;
            w_addressed = 1'b0;
            w_stop_p    = r_addressed;
        end else begin
            case (r_state)
                ST_ADDR: if (w_rise) begin
                    w_shift = w_shift_in;
                    if (r_bitcnt == 3'd0) begin
                        // the seven bits already shifted are the address; this bit is R/W
                        if (r_shift[ADDR_SIZE-1:0] == SLAVE_ADDR) begin
                            w_rw    = w_sda;
                            w_ackph = 1'b0;
                            w_state = ST_ADDR_ACK;
                        end else begin
                            w_state = ST_IGNORE;
                        end
                    end else begin
                        w_bitcnt = r_bitcnt - 3'd1;
                    end
                end
                ST_ADDR_ACK: begin
                    if (r_wait) begin
                        if (tx_valid_i) w_load = 1'b1;
                    end else if (w_fall) begin
                        if (!r_ackph) begin
                            w_sda_en = 1'b1;
                            w_ackph  = 1'b1;
                        end else begin
                            w_sda_en    = 1'b0;
                            w_addressed = 1'b1;
                            if (r_rw == RW_READ) begin
                                w_load = 1'b1;
                            end else begin
                                w_state  = ST_WR_DATA;
                                w_bitcnt = 3'd7;
                            end
                        end
                    end
                end
                ST_WR_DATA: if (w_rise) begin
                    w_shift = w_shift_in;
                    if (r_bitcnt == 3'd0) begin
                        w_rx_ok = rx_ready_i;
                        w_ackph = 1'b0;
                        w_state = ST_WR_ACK;
                        if (rx_ready_i) begin
                            w_rx_data  = w_shift_in;
                            w_rx_valid = 1'b1;
                        end
                    end else begin
                        w_bitcnt = r_bitcnt - 3'd1;
                    end
                end
                ST_WR_ACK: begin
                    if (r_wait) begin
                        if (rx_ready_i) begin
                            w_rx_data  = r_shift;
                            w_rx_valid = 1'b1;
                            w_sda_en   = 1'b1;
                            w_ackph    = 1'b1;
                            w_scl_en   = 1'b0;
                            w_wait     = 1'b0;
                        end
                    end else if (w_fall) begin
                        if (!r_ackph) begin
                            if (r_rx_ok) begin
                                w_sda_en = 1'b1;
                                w_ackph  = 1'b1;
                            end else if (STRETCH) begin
                                w_scl_en = 1'b1;
                                w_wait   = 1'b1;
                            end else begin
                                w_state = ST_IGNORE;
                            end
                        end else begin
                            w_sda_en = 1'b0;
                            w_state  = ST_WR_DATA;
                            w_bitcnt = 3'd7;
                        end
                    end
                end
                ST_RD_DATA: if (w_fall) begin
                    if (r_bitcnt == 3'd0) begin
                        w_sda_en = 1'b0;
                        w_ackph  = 1'b0;
                        w_state  = ST_RD_ACK;
                    end else begin
                        w_shift  = {r_shift[DATA_SIZE-2:0], 1'b0};
                        w_sda_en = ~r_shift[DATA_SIZE-2];
                        w_bitcnt = r_bitcnt - 3'd1;
                    end
                end
                ST_RD_ACK: begin
                    if (r_wait) begin
                        if (tx_valid_i) w_load = 1'b1;
                    end else if (w_rise) begin
                        if (w_sda == ACK) w_ackph = 1'b1;
                        else              w_state = ST_IGNORE;
                    end else if (w_fall && r_ackph) begin
                        w_load = 1'b1;
                    end
                end
                default: ;
            endcase

            // byte fetch for a read; drives the MSB on the same fall
            if (w_load) begin
                if (STRETCH && !tx_valid_i) begin
                    w_scl_en = 1'b1;
                    w_wait   = 1'b1;
                end else begin
                    w_shift    = w_byte_ld;
                    w_sda_en   = ~w_byte_ld[DATA_SIZE-1];
                    w_bitcnt   = 3'd7;
                    w_state    = ST_RD_DATA;
                    w_tx_ready = tx_valid_i;
                    w_underrun = ~tx_valid_i;
                    w_scl_en   = 1'b0;
                    w_wait     = 1'b0;
                end
            end
        end
    end

    assign i2c_sda_en_o = r_sda_en;
    assign i2c_scl_en_o = r_scl_en;
    assign rx_data_o    = r_rx_data;
    assign rx_valid_o   = r_rx_valid;
    assign tx_ready_o   = r_tx_ready;
    assign addressed_o  = r_addressed;
    assign rw_o         = r_rw;
    assign stop_o       = r_stop;
    assign underrun_o   = r_underrun;

    logic w_unused;
    assign w_unused = w_scl;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Scoreboard bench for i2c_slave_fsm: bit-banged I2C master, open-drain bus model,
// queue-based expected rx bytes / read bytes popped by a negedge monitor.
module tb_i2c_slave_fsm;
    import i2c_pkg::*;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       scl_bus, sda_bus;
    logic       sda_en, scl_en;
    logic [7:0] rx_data;
    logic       rx_valid, tx_ready, addressed, rw, stop_p, underrun;
    logic       rx_ready = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    always #5 clk = ~clk;

    assign scl_bus = m_scl & ~scl_en;
    assign sda_bus = m_sda & ~sda_en;

    i2c_slave_fsm dut (
        .i2c_core_clk_i (clk),
        .reset_ni       (rst_n),
        .i2c_scl_i      (scl_bus),
        .i2c_sda_i      (sda_bus),
        .i2c_sda_en_o   (sda_en),
        .i2c_scl_en_o   (scl_en),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .rx_ready_i     (rx_ready),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_ready_o     (tx_ready),
        .addressed_o    (addressed),
        .rw_o           (rw),
        .stop_o         (stop_p),
        .underrun_o     (underrun)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] tx_src[$];
    int n_rxv = 0, n_txr = 0, n_und = 0, n_stop = 0, n_sdaen = 0, n_addr = 0;
    logic       rd_done = 1'b0;
    logic [7:0] rd_byte = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor/scoreboard plus the client-side tx supply
    always @(negedge clk) begin
        logic [7:0] e;
        if (rx_valid) begin
            if (exp_rx.size() == 0) chk("rx_unexpected", 32'(rx_data), 32'h1ff);
            else begin e = exp_rx.pop_front(); chk("rx_data", 32'(rx_data), 32'(e)); end
        end
        if (rd_done) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 32'(rd_byte), 32'h1ff);
            else begin e = exp_rd.pop_front(); chk("rd_byte", 32'(rd_byte), 32'(e)); end
        end
        if (rst_n) begin
            n_rxv   += int'(rx_valid);
            n_txr   += int'(tx_ready);
            n_und   += int'(underrun);
            n_stop  += int'(stop_p);
            n_sdaen += int'(sda_en);
            n_addr  += int'(addressed);
        end
        if (tx_ready && tx_src.size() > 0) void'(tx_src.pop_front());
        tx_valid = (tx_src.size() > 0);
        tx_data  = (tx_src.size() > 0) ? tx_src[0] : 8'h00;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scl_rel();
        m_scl = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (scl_bus) break;
            @(posedge clk);
            #1;
        end
        if (!scl_bus) begin
            checks++;
            errors++;
            $display("FAIL scl_release_timeout: scl=%0b required 1", scl_bus);
        end
    endtask

    task automatic start_c();
        m_sda = 1'b1; cyc(Q);
        scl_rel();    cyc(Q);
        m_sda = 1'b0; cyc(2*Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic stop_c();
        m_sda = 1'b0; cyc(Q);
        scl_rel();    cyc(Q);
        m_sda = 1'b1; cyc(2*Q);
    endtask

    task automatic wbit(input logic b);
        m_sda = b;    cyc(Q);
        scl_rel();    cyc(2*Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1; cyc(Q);
        scl_rel();    cyc(Q);
        b = sda_bus;  cyc(Q);
        m_scl = 1'b0; cyc(Q);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(input logic ack_out);
        logic b;
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin rbit(b); v = {v[6:0], b}; end
        rd_byte = v;
        @(posedge clk); rd_done = 1'b1;
        @(posedge clk); rd_done = 1'b0;
        #1;
        wbit(ack_out);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic ack;
        int s_rxv, s_txr, s_und, s_stop, s_sdaen, s_addr;

        // reset state
        cyc(3);
        chk("rst_sda_en", 32'(sda_en), 0);
        chk("rst_scl_en", 32'(scl_en), 0);
        chk("rst_addressed", 32'(addressed), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_pulses", 32'({rx_valid, tx_ready, stop_p, underrun, rw}), 0);
        rst_n = 1'b1;
        cyc(5);

        // write 0xA5 to address 0x50
        s_rxv = n_rxv; s_stop = n_stop;
        start_c();
        wbyte(8'hA0, ack); chk("wr_addr_ack", 32'(ack), 32'(ACK));
        exp_rx.push_back(8'hA5);
        wbyte(8'hA5, ack); chk("wr_data_ack", 32'(ack), 32'(ACK));
        chk("wr_addressed", 32'(addressed), 1);
        chk("wr_rw", 32'(rw), 0);
        stop_c(); cyc(5);
        chk("wr_rx_pulses", 32'(n_rxv - s_rxv), 1);
        chk("wr_stop_pulses", 32'(n_stop - s_stop), 1);
        chk("wr_rx_leftover", 32'(exp_rx.size()), 0);

        // address mismatch (0x51)
        s_rxv = n_rxv; s_stop = n_stop; s_sdaen = n_sdaen; s_addr = n_addr;
        start_c();
        wbyte(8'hA2, ack); chk("mm_addr_nack", 32'(ack), 32'(NACK));
        wbyte(8'h3C, ack); chk("mm_data_nack", 32'(ack), 32'(NACK));
        stop_c(); cyc(5);
        chk("mm_sda_en_cycles", 32'(n_sdaen - s_sdaen), 0);
        chk("mm_addressed_cycles", 32'(n_addr - s_addr), 0);
        chk("mm_rx_pulses", 32'(n_rxv - s_rxv), 0);
        chk("mm_stop_pulses", 32'(n_stop - s_stop), 0);

        // read two bytes, ACK then NACK
        s_txr = n_txr; s_und = n_und;
        tx_src.push_back(8'hC3); tx_src.push_back(8'h5A);
        cyc(2);
        start_c();
        wbyte(8'hA1, ack); chk("rd_addr_ack", 32'(ack), 32'(ACK));
        chk("rd_rw", 32'(rw), 1);
        exp_rd.push_back(8'hC3); exp_rd.push_back(8'h5A);
        rbyte(ACK);
        rbyte(NACK);
        cyc(2);
        chk("rd_state_ignore", 32'(dut.r_state), 32'(ST_IGNORE));
        stop_c(); cyc(5);
        chk("rd_tx_ready_pulses", 32'(n_txr - s_txr), 2);
        chk("rd_underrun_pulses", 32'(n_und - s_und), 0);
        chk("rd_leftover", 32'(exp_rd.size()), 0);

        // read with no data available
        s_txr = n_txr; s_und = n_und;
        start_c();
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        fork
            begin
                for (int i = 0; i < 3000 && !scl_en; i++) cyc(1);
                cyc(3);
                tx_src.push_back(8'h96);
            end
        join_none
        exp_rd.push_back(8'h96);
`else
        exp_rd.push_back(8'hFF);
`endif
        wbyte(8'hA1, ack); chk("ur_addr_ack", 32'(ack), 32'(ACK));
        rbyte(NACK);
        stop_c(); cyc(5);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        chk("ur_underrun_pulses", 32'(n_und - s_und), 0);
        chk("ur_tx_ready_pulses", 32'(n_txr - s_txr), 1);
`else
        chk("ur_underrun_pulses", 32'(n_und - s_und), 1);
        chk("ur_tx_ready_pulses", 32'(n_txr - s_txr), 0);
`endif
        chk("ur_leftover", 32'(exp_rd.size()), 0);

        // repeated START after 4 bits of a write byte, then read
        s_rxv = n_rxv; s_txr = n_txr;
        tx_src.push_back(8'h3E);
        cyc(2);
        start_c();
        wbyte(8'hA0, ack); chk("rs_addr_ack", 32'(ack), 32'(ACK));
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
        start_c();
        chk("rs_addressed_dropped", 32'(addressed), 0);
        wbyte(8'hA1, ack); chk("rs_raddr_ack", 32'(ack), 32'(ACK));
        exp_rd.push_back(8'h3E);
        rbyte(NACK);
        stop_c(); cyc(5);
        chk("rs_rx_pulses", 32'(n_rxv - s_rxv), 0);
        chk("rs_tx_ready_pulses", 32'(n_txr - s_txr), 1);
        chk("rs_leftover", 32'(exp_rd.size()), 0);

        // reset asserted in the middle of the address ACK slot
        start_c();
        for (int i = 7; i >= 0; i--) wbit(i == 5 || i == 7);
        m_sda = 1'b1; cyc(Q);
        chk("rst_ack_driven", 32'(sda_en), 1);
        scl_rel(); cyc(Q);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack_released", 32'(sda_en), 0);
        chk("rst_ack_addressed", 32'(addressed), 0);
        cyc(5);
        rst_n = 1'b1;
        cyc(10);
        chk("rst_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
        chk("rst_idle_sda_en", 32'(sda_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_slave_fsm.md
Name: i2c_slave_fsm

Overview:
- I2C target (slave) controller; the responder end of the bus that the i2c master core initiates on.
- Watches SCL/SDA, detects START/STOP, matches a fixed 7-bit address, ACKs it, then receives write bytes or transmits read bytes.
- Sits between the open-drain pads and a byte-wide client interface (register file or FIFO).
- Drives lines only by pulling low through enable outputs; never drives high.

Parameters:
- DATA_SIZE, 8, width of the data byte; only 8 is legal.
- ADDR_SIZE, 7, width of the target address.
- SLAVE_ADDR, 7'h50, the target address this instance responds to.

Ports:
- i2c_core_clk_i  in  1  core clock; must run at least 16x the SCL rate.
- reset_ni  in  1  asynchronous active-low reset.
- i2c_scl_i  in  1  SCL line as seen at the pad; asynchronous.
- i2c_sda_i  in  1  SDA line as seen at the pad; asynchronous.
- i2c_sda_en_o  out  1  1 = pull SDA low.
- i2c_scl_en_o  out  1  1 = pull SCL low (clock stretch); see Optional Feature.
- rx_data_o  out  DATA_SIZE  last byte received from the master.
- rx_valid_o  out  1  one-cycle pulse; rx_data_o is new.
- rx_ready_i  in  1  client can accept a byte; sampled at the 8th data bit.
- tx_data_i  in  DATA_SIZE  byte to return to the master.
- tx_valid_i  in  1  tx_data_i is valid.
- tx_ready_o  out  1  one-cycle pulse; tx_data_i was consumed.
- addressed_o  out  1  high from address ACK until STOP, repeated START or mismatch.
- rw_o  out  1  R/W bit of the current transfer.
- stop_o  out  1  one-cycle pulse on a STOP detected while addressed.
- underrun_o  out  1  one-cycle pulse when a read byte was needed and tx_valid_i was low.

Behaviour:
- Reset: every output is 0 and the state is IDLE. Assertion mid-transfer releases SDA and SCL immediately; no bus activity resumes until the next START.
- Synchronisation: SCL and SDA pass through 2-flop synchronisers. Edges are detected on the synchronised values, so the latency from pad to action is 3 clocks.
- START: synchronised SDA falls while SCL is high. Valid in any state, including repeated START mid-byte. Action: go to ADDR, clear the bit counter, release SDA, drop addressed_o.
- STOP: synchronised SDA rises while SCL is high. Valid in any state. Action: go to IDLE, release SDA, pulse stop_o if addressed_o was high.
- START and STOP take priority over any same-cycle SCL edge.
- Sampling and driving: incoming bits are sampled on the SCL rising edge. SDA changes are made on the SCL falling edge. Bytes are MSB first; a 3-bit counter runs 7..0.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- ADDR: shift in 8 bits (address + R/W).
  - After the 8th rise, on match: latch rw_o, go to ADDR_ACK.
  - On mismatch: go to IGNORE and never touch SDA until the next START.
- ADDR_ACK:
  - On the next SCL fall, set i2c_sda_en_o=1.
  - On the following fall, release SDA and set addressed_o=1.
  - If rw=0, go to WR_DATA.
  - If rw=1, load tx_data_i, pulse tx_ready_o, drive bit 7 on the same fall, go to RD_DATA.
  - If rw=1 and tx_valid_i is low, load 8'hFF and pulse underrun_o instead of tx_ready_o.
- WR_DATA: after the 8th rise, rx_data_o is updated and rx_valid_o pulses for one clock. This happens only if rx_ready_i=1; otherwise rx_data_o holds and no pulse occurs.
- WR_ACK:
  - If rx_ready_i was 1 at the 8th bit: drive ACK for one SCL period, then return to WR_DATA.
  - Otherwise: NACK (SDA released), go to IGNORE.
- RD_DATA: on each SCL fall, i2c_sda_en_o = ~current bit. After the 8th bit, release SDA on the next fall and go to RD_ACK.
- RD_ACK: sample SDA on the SCL rise.
  - 0 (ACK): load the next byte on the following fall, with the same valid/underrun rule as ADDR_ACK, and return to RD_DATA.
  - 1 (NACK): go to IGNORE; the master will STOP or repeat START.
- The general-call address (0x00) is not recognised and is treated as a mismatch.

Optional Feature:
- Macro I2C_SLAVE_CLK_STRETCH_EN.
- Defined: instead of underrun or NACK, the block holds SCL low (i2c_scl_en_o=1) after the SCL fall where data is needed.
  - Read: holds while tx_valid_i is 0.
  - Write ACK: holds while rx_ready_i is 0.
  - SCL is released one clock after the condition clears. underrun_o never pulses, and WR_ACK always ACKs.
- Not defined: i2c_scl_en_o is tied to 0 and the underrun/NACK rules above apply.

Decomposition:
- Shared package i2c_pkg contents:
  - slave state enum
  - ACK=1'b0 and NACK=1'b1 constants
  - the DATA_SIZE default
  - the R/W bit encoding (READ=1)
- One natural sub-module, i2c_line_sync: 2-flop synchronisers plus scl_rise/scl_fall/start_det/stop_det pulses. It is reusable by the master FSM.

Test Plan:
- Address match: START, address 0x50 with W, then 0xA5, then STOP. Required: SDA pulled low in both ACK slots; rx_data_o=8'hA5 with one rx_valid_o pulse; stop_o pulses once.
- Address mismatch: START, address 0x51 with W, then 0x3C. Required: i2c_sda_en_o stays 0 throughout; no rx_valid_o; addressed_o stays 0.
- Read two bytes: tx_data_i supplies 0xC3 then 0x5A; master ACKs the first byte and NACKs the second. Required: bits seen on SDA are 11000011 then 01011010; two tx_ready_o pulses; IGNORE state reached.
- Read underrun: tx_valid_i=0 at the address ACK fall. Required: 0xFF is shifted out and underrun_o pulses (macro off). With the macro on, SCL is held low until tx_valid_i=1 and the correct byte follows.
- Interruptions: a repeated START after the 4th bit of a write byte, followed by address 0x50 with R. Required: no rx_valid_o for the partial byte; the read proceeds normally. Separately, asserting reset_ni low mid-ACK releases i2c_sda_en_o on the same clock.
